// File: rtl/ajuste_pulsadores.sv
// Adjust push-button conditioner: two-flop synchroniser, debouncer and
// press/auto-repeat pulse generator driving an up/down/EN adjust counter.
module ajuste_pulsadores #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned REP_DELAY  = 50000000,
    parameter int unsigned REP_PERIOD = 20000000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    input  logic enable,
    output logic up,
    output logic down,
    output logic en
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REP_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        HOLD_UP,
        RPT_UP,
        HOLD_DN,
        RPT_DN,
        LOCK
    } state_t;

    // Bit 0 carries the up button, bit 1 the down button.
    logic [1:0]       sync_a;
    logic [1:0]       sync_b;
    logic [1:0]       deb;
    logic [CNT_W-1:0] deb_cnt [2];

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic [CNT_W-1:0] tmr_last;
    logic             up_nxt;
    logic             dn_nxt;
    logic             du;
    logic             dd;

    assign du = deb[0];
    assign dd = deb[1];

    // Synchronise both raw buttons and debounce each synchronised level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_a     <= '0;
            sync_b     <= '0;
            deb        <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync_a <= {btn_down, btn_up};
            sync_b <= sync_a;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync_b[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // State, repeat timer and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            timer <= '0;
            up    <= 1'b0;
            down  <= 1'b0;
            en    <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            up    <= up_nxt;
            down  <= dn_nxt;
            en    <= up_nxt | dn_nxt;
        end
    end

    // Next state and pulse decode; only one of up/down can ever be requested.
    always_comb begin
        state_nxt = state;
        timer_nxt = '0;
        up_nxt    = 1'b0;
        dn_nxt    = 1'b0;
        tmr_last  = ((state == HOLD_UP) || (state == HOLD_DN)) ? DLY_LAST : PER_LAST;

        if (!enable) begin
            state_nxt = LOCK;
        end else begin
            case (state)
                IDLE: begin
                    if (du && dd) begin
                        state_nxt = LOCK;
                    end else if (du) begin
                        up_nxt    = 1'b1;
                        state_nxt = HOLD_UP;
                    end else if (dd) begin
                        dn_nxt    = 1'b1;
                        state_nxt = HOLD_DN;
                    end
                end
                HOLD_UP, RPT_UP: begin
                    if (!du) begin
                        state_nxt = IDLE;
                    end else if (dd) begin
                        state_nxt = LOCK;
                    end else if (timer == tmr_last) begin
                        up_nxt    = 1'b1;
                        state_nxt = RPT_UP;
                    end else begin
                        timer_nxt = timer + CNT_ONE;
                    end
                end
                HOLD_DN, RPT_DN: begin
                    if (!dd) begin
                        state_nxt = IDLE;
                    end else if (du) begin
                        state_nxt = LOCK;
                    end else if (timer == tmr_last) begin
                        dn_nxt    = 1'b1;
                        state_nxt = RPT_DN;
                    end else begin
                        timer_nxt = timer + CNT_ONE;
                    end
                end
                LOCK: begin
                    if (!du && !dd) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ajuste_pulsadores.sv
// Bench for ajuste_pulsadores: scripted segments with hand-derived pulse
// counts plus a cycle-by-cycle comparison against a behavioural model.
module tb_ajuste_pulsadores;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic clk = 1'b0;
    logic rst;
    logic btn_up;
    logic btn_down;
    logic enable;
    logic up;
    logic down;
    logic en;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit chk_on = 1'b0;

    ajuste_pulsadores #(
        .DEB_CYCLES(DEB),
        .REP_DELAY (RD),
        .REP_PERIOD(RP),
        .CNT_W     (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .enable  (enable),
        .up      (up),
        .down    (down),
        .en      (en)
    );

    always #5 clk = ~clk;

    // Behavioural reference: debounced levels from run lengths, pulses from
    // the age of the current solo press.
    logic [1:0] m_s1 = '0;
    logic [1:0] m_s2 = '0;
    logic [1:0] m_deb = '0;
    int         m_run [2] = '{0, 0};
    bit         m_lock = 1'b0;
    int         m_owner = 0;
    int         m_age = 0;
    bit         exp_up = 1'b0;
    bit         exp_dn = 1'b0;
    bit         m_own;
    bit         m_other;

    function automatic bit repeat_due(input int age);
        return (age == RD) || ((age > RD) && (((age - RD) % RP) == 0));
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            m_run[0] = 0; m_run[1] = 0;
            m_lock = 1'b0; m_owner = 0; m_age = 0;
            exp_up = 1'b0; exp_dn = 1'b0;
        end else begin
            exp_up = 1'b0;
            exp_dn = 1'b0;
            if (!enable) begin
                m_lock = 1'b1;
                m_owner = 0;
            end else if (m_lock) begin
                if (m_deb == 2'b00) m_lock = 1'b0;
            end else if (m_owner == 0) begin
                if (m_deb == 2'b11) m_lock = 1'b1;
                else if (m_deb[0]) begin m_owner = 1; m_age = 0; exp_up = 1'b1; end
                else if (m_deb[1]) begin m_owner = 2; m_age = 0; exp_dn = 1'b1; end
            end else begin
                m_own   = m_deb[m_owner - 1];
                m_other = m_deb[2 - m_owner];
                if (!m_own) m_owner = 0;
                else if (m_other) begin m_lock = 1'b1; m_owner = 0; end
                else begin
                    m_age++;
                    if (repeat_due(m_age)) begin
                        if (m_owner == 1) exp_up = 1'b1;
                        else exp_dn = 1'b1;
                    end
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (m_s2[b] == m_deb[b]) m_run[b] = 0;
                else begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_deb[b] = m_s2[b];
                        m_run[b] = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = {btn_down, btn_up};
        end
    end

    // Per-cycle comparison of outputs against the model, plus exclusivity.
    always @(negedge clk) begin
        cycle++;
        if (chk_on) begin
            checks++;
            if (up !== exp_up || down !== exp_dn || en !== (exp_up | exp_dn)) begin
                errors++;
                $display("FAIL cycle %0d outputs: got up=%b down=%b en=%b expected up=%b down=%b en=%b",
                         cycle, up, down, en, exp_up, exp_dn, exp_up | exp_dn);
            end
            checks++;
            if (up === 1'b1 && down === 1'b1) begin
                errors++;
                $display("FAIL cycle %0d exclusive: got up=1 down=1 expected not both", cycle);
            end
        end
    end

    typedef struct {
        logic r;
        logic e;
        logic bu;
        logic bd;
        int   cyc;
        int   n_up;
        int   n_dn;
        int   first;
    } seg_t;

    seg_t tbl[$];

    task automatic add(input logic r, input logic e, input logic bu, input logic bd,
                       input int cyc, input int nu, input int nd, input int first);
        seg_t s;
        s = '{r, e, bu, bd, cyc, nu, nd, first};
        tbl.push_back(s);
    endtask

    task automatic check(input string name, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL seg%0d %s: got %0d expected %0d", idx, name, got, exp);
        end
    endtask

    task automatic run_seg(input int idx, input seg_t s, input bit scored);
        int nu;
        int nd;
        int first;
        nu = 0; nd = 0; first = 0;
        rst = s.r; enable = s.e; btn_up = s.bu; btn_down = s.bd;
        for (int c = 1; c <= s.cyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (up === 1'b1) nu++;
            if (down === 1'b1) nd++;
            if ((up === 1'b1 || down === 1'b1) && first == 0) first = c;
        end
        if (scored) begin
            check("up_count", idx, nu, s.n_up);
            check("down_count", idx, nd, s.n_dn);
            check("first_pulse", idx, first, s.first);
        end
    endtask

    initial begin
        seg_t rs;
        rst = 1'b0; enable = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;

        // rst, enable, btn_up, btn_down, cycles, up pulses, down pulses, first pulse cycle
        // Reset with button held, then the press seen after release.
        add(0, 1, 1, 0,  2, 0, 0, 0);
        add(1, 1, 1, 0,  8, 1, 0, 7);
        add(1, 1, 0, 0, 12, 0, 0, 0);
        // Clean single press.
        add(1, 1, 1, 0,  8, 1, 0, 7);
        add(1, 1, 0, 0, 12, 0, 0, 0);
        // Bounce on down: runs of at most three.
        add(1, 1, 0, 1,  1, 0, 0, 0);
        add(1, 1, 0, 0,  1, 0, 0, 0);
        add(1, 1, 0, 1,  2, 0, 0, 0);
        add(1, 1, 0, 0,  1, 0, 0, 0);
        add(1, 1, 0, 1,  3, 0, 0, 0);
        add(1, 1, 0, 0, 10, 0, 0, 0);
        // Auto-repeat: 7,17,22,27,32,37 then one more at 42 before release settles.
        add(1, 1, 1, 0, 40, 6, 0, 7);
        add(1, 1, 0, 0, 12, 1, 0, 2);
        // Both buttons: down arrives just as the first repeat would fire.
        add(1, 1, 1, 0, 10, 1, 0, 7);
        add(1, 1, 1, 1, 20, 0, 0, 0);
        add(1, 1, 0, 1, 12, 0, 0, 0);
        add(1, 1, 0, 0, 10, 0, 0, 0);
        add(1, 1, 0, 1,  8, 0, 1, 7);
        add(1, 1, 0, 0, 12, 0, 0, 0);
        // Enable gating.
        add(1, 0, 1, 0, 30, 0, 0, 0);
        add(1, 1, 1, 0, 10, 0, 0, 0);
        add(1, 1, 0, 0, 10, 0, 0, 0);
        add(1, 1, 1, 0,  8, 1, 0, 7);
        add(1, 1, 0, 0, 12, 0, 0, 0);
        // Reset mid-hold.
        add(1, 1, 1, 0, 20, 2, 0, 7);
        add(0, 1, 1, 0,  2, 0, 0, 0);
        add(1, 1, 1, 0,  8, 1, 0, 7);
        add(1, 1, 0, 0, 12, 0, 0, 0);
        // Simultaneous press edges.
        add(1, 1, 1, 1, 10, 0, 0, 0);
        add(1, 1, 0, 0, 10, 0, 0, 0);
        // Enable dropped during a hold.
        add(1, 1, 1, 0, 10, 1, 0, 7);
        add(1, 0, 1, 0,  5, 0, 0, 0);
        add(1, 1, 0, 0, 12, 0, 0, 0);

        foreach (tbl[i]) run_seg(i, tbl[i], 1'b1);

        // Random segments checked only by the cycle model.
        for (int k = 0; k < 300; k++) begin
            rs.r    = ($urandom_range(0, 40) != 0);
            rs.e    = ($urandom_range(0, 12) != 0);
            rs.bu   = ($urandom_range(0, 2) == 0);
            rs.bd   = ($urandom_range(0, 2) == 0);
            rs.cyc  = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
            rs.n_up = 0; rs.n_dn = 0; rs.first = 0;
            run_seg(k, rs, 1'b0);
        end

        rs = '{1'b1, 1'b1, 1'b0, 1'b0, 20, 0, 0, 0};
        run_seg(999, rs, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ajuste_pulsadores.md
Name: ajuste_pulsadores

Overview:
- Front-end conditioner for the two adjust push-buttons of the time/date setting path.
- Synchronises and debounces the raw buttons, then converts each press into single-cycle up/down/EN pulses.
- Auto-repeats while a button is held.
- Outputs drive the up/down/EN inputs of the 1–12 wrap-around adjust counter directly.
- Guarantees up and down are never asserted together, so the counter's both-asserted error code (8'hFF) is never triggered.

Parameters:
- DEB_CYCLES, 1000000, consecutive cycles a synchronised button must differ from its debounced level before the level flips (10 ms at 100 MHz).
- REP_DELAY, 50000000, cycles from the first pulse to the first auto-repeat pulse.
- REP_PERIOD, 20000000, cycles between subsequent auto-repeat pulses.
- CNT_W, 32, width of the debounce and repeat timers; must hold max(DEB_CYCLES, REP_DELAY, REP_PERIOD).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-low reset; rst==0 sampled on a clk rising edge resets the block.
- btn_up  in  1  raw up button, active-high, asynchronous, bouncy.
- btn_down  in  1  raw down button, active-high, asynchronous, bouncy.
- enable  in  1  adjust mode active; when low, no pulses are issued.
- up  out  1  one-cycle increment pulse, registered.
- down  out  1  one-cycle decrement pulse, registered.
- en  out  1  registered; equals up|down in the same cycle.

Behaviour:
- Reset (rst==0 at a clk edge):
  - up, down, en = 0.
  - Synchroniser flops, debounced levels and timers = 0.
  - FSM = IDLE.
- Synchroniser: two flops per button.
- Debouncer, per button:
  - Synchronised value == debounced level: counter <= 0.
  - Values differ and counter < DEB_CYCLES-1: counter increments.
  - Values differ and counter == DEB_CYCLES-1: debounced level <= synchronised value, counter <= 0.
  - Any glitch shorter than DEB_CYCLES synchronised cycles is rejected.
- Press latency: counting the first clk edge that samples btn high as edge 1, the first pulse is high after edge DEB_CYCLES+3 and stays high for exactly one cycle.
- FSM states (du/dd = debounced up/down):
  - IDLE:
    - du & !dd: pulse up; go HOLD_UP; timer <= 0.
    - dd & !du: pulse down; go HOLD_DN; timer <= 0.
    - du & dd: go LOCK, no pulse.
    - Neither pressed: stay.
  - HOLD_x:
    - Own button released: go IDLE.
    - Other button also pressed: go LOCK, no pulse.
    - Timer == REP_DELAY-1: pulse x; go RPT_x; timer <= 0.
    - Otherwise: timer increments.
  - RPT_x: same as HOLD_x, but the period is REP_PERIOD; pulse and timer <= 0 each time it expires.
  - LOCK: no pulses; go IDLE only when du==0 and dd==0.
- Pulse spacing while held:
  - First to second pulse: REP_DELAY cycles.
  - Thereafter: REP_PERIOD cycles.
- enable==0:
  - FSM forced to LOCK every cycle; outputs 0.
  - Debouncers keep running.
  - On return of enable, a button already held must be released and re-pressed before any pulse.
- Simultaneous press edges (both debounced levels rise in the same cycle): LOCK, no pulse.
- Reset mid-hold: returns to IDLE with debounced levels 0. A button still physically held is then seen as a new press, giving one pulse DEB_CYCLES+3 edges after reset release.
- up and down are mutually exclusive in every cycle by construction.

Test Plan:
All tests use DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=5.
1. Reset: rst=0 for 2 cycles while btn_up=1 → up=down=en=0 during reset. After rst=1, exactly one up pulse appears after edge 7 counted from reset release.
2. Clean single press: btn_up high for 12 cycles, then low → exactly one up pulse (en=1 in the same cycle), high after edge 7 from the first sampled edge; no down pulse.
3. Bounce rejection: btn_down toggles 1,0,1,1,0,1,1,1,0 (runs ≤3 cycles), then stays 0 → zero pulses.
4. Auto-repeat: btn_up held 40 cycles after the debounced level rises → pulses at t0, t0+10, t0+15, t0+20, t0+25, … (every 5 cycles) until release. None after the debounced release.
5. Both buttons: press up; while held, press down → no further up pulses. Release up with down still held → no down pulse. Release both, then press down → one down pulse. Up and down are never both 1 in any cycle.
6. Enable gating: enable=0, press btn_up for 30 cycles → no pulses. Raise enable while still held → no pulse. Release, re-press → one up pulse after latency.
